// File: rtl/tkx_share_bank.sv
// Masked TK1 key bank: SHARES Boolean shares, loaded serially over sdi, updated one share per cycle.
// Optional IDLE-time share re-randomisation is built only when TKX_SHARE_BANK_REFRESH_EN is defined.
module tkx_share_bank #(
  parameter int SHARES  = 2,
  parameter int BUSW    = 32,
  parameter int NROUNDS = 40
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [BUSW-1:0]         sdi,
  input  logic                    sdi_valid,
  output logic                    sdi_ready,
  input  logic                    start,
  input  logic                    correct,
  input  logic [128*SHARES-1:0]   tkxtbc,
  input  logic [128*SHARES-1:0]   tkxcorrect,
`ifdef TKX_SHARE_BANK_REFRESH_EN
  input  logic                    refresh,
  input  logic [127:0]            rdi,
`endif
  output logic [128*SHARES-1:0]   tkx,
  output logic [SHARES-1:0]       ring_en,
  output logic [5:0]              round_cnt,
  output logic                    busy,
  output logic                    done
);

  localparam int TW  = 128 * SHARES;
  localparam int W   = TW / BUSW;
  localparam int WCW = (W > 1) ? $clog2(W) : 1;
  localparam int PW  = (SHARES > 1) ? $clog2(SHARES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_TBC, S_CORRECT} state_t;

  state_t            r_state;
  logic [TW-1:0]     r_tkx;
  logic [SHARES-1:0] r_ring;
  logic [5:0]        r_round;
  logic [WCW-1:0]    r_wcnt;
  logic [PW-1:0]     r_ptr;
  logic              r_corr;
  logic              r_busy;
  logic              r_done;
  logic              r_sdi_ready;

  logic [TW-1:0]     w_shift;
  logic              w_last_share;
  logic [5:0]        w_round_nxt;

  // Shifting by the full width leaves zero, so BUSW == TW degenerates to tkx <= sdi.
  assign w_shift      = (r_tkx << BUSW) | TW'(sdi);
  assign w_last_share = (r_ptr == PW'(SHARES - 1));
  assign w_round_nxt  = r_round + 6'd1;

`ifdef TKX_SHARE_BANK_REFRESH_EN
  logic [TW-1:0] w_rmask;
  // Same mask on share0 and share1 keeps the XOR of all shares invariant.
  assign w_rmask = (SHARES >= 2) ? TW'({rdi, rdi}) : '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_tkx       <= '0;
      r_ring      <= '0;
      r_round     <= '0;
      r_wcnt      <= '0;
      r_ptr       <= '0;
      r_corr      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_sdi_ready <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (load) begin
            r_state     <= S_LOAD;
            r_busy      <= 1'b1;
            r_sdi_ready <= 1'b1;
            r_wcnt      <= '0;
          end else if (start) begin
            r_state <= S_TBC;
            r_busy  <= 1'b1;
            r_corr  <= correct;
            r_ptr   <= '0;
            r_round <= '0;
            r_ring  <= SHARES'(1);
          end
`ifdef TKX_SHARE_BANK_REFRESH_EN
          else if (refresh) begin
            r_tkx <= r_tkx ^ w_rmask;
          end
`endif
        end

        S_LOAD: begin
          if (sdi_valid) begin
            r_tkx <= w_shift;
            if (r_wcnt == WCW'(W - 1)) begin
              r_state     <= S_IDLE;
              r_busy      <= 1'b0;
              r_sdi_ready <= 1'b0;
              r_done      <= 1'b1;
            end else begin
              r_wcnt <= r_wcnt + WCW'(1);
            end
          end
        end

        S_TBC: begin
          r_tkx[128*r_ptr +: 128] <= tkxtbc[128*r_ptr +: 128];
          if (w_last_share) begin
            r_ptr   <= '0;
            r_round <= w_round_nxt;
            if (w_round_nxt == 6'(NROUNDS)) begin
              if (r_corr) begin
                r_state <= S_CORRECT;
                r_ring  <= SHARES'(1);
              end else begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_ring  <= '0;
              end
            end else begin
              r_ring <= SHARES'(1);
            end
          end else begin
            r_ptr  <= r_ptr + PW'(1);
            r_ring <= SHARES'(1) << (r_ptr + PW'(1));
          end
        end

        S_CORRECT: begin
          r_tkx[128*r_ptr +: 128] <= tkxcorrect[128*r_ptr +: 128];
          if (w_last_share) begin
            r_ptr   <= '0;
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_ring  <= '0;
          end else begin
            r_ptr  <= r_ptr + PW'(1);
            r_ring <= SHARES'(1) << (r_ptr + PW'(1));
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign tkx       = r_tkx;
  assign ring_en   = r_ring;
  assign round_cnt = r_round;
  assign busy      = r_busy;
  assign done      = r_done;
  assign sdi_ready = r_sdi_ready;

endmodule

// File: tb/tb_tkx_share_bank.sv
// Bench for tkx_share_bank (SHARES=2, BUSW=32, NROUNDS=40): table-driven TBC runs with
// ring_en/key scoreboards, plus load, stall, reset and priority sequences.
module tb_tkx_share_bank;

  localparam int SHARES  = 2;
  localparam int BUSW    = 32;
  localparam int NROUNDS = 40;
  localparam int TW      = 128 * SHARES;
  localparam logic [127:0] CMASK = 128'h0F0F_0F0F_1234_5678_9ABC_DEF0_F0F0_F0F0;

  logic              clk = 1'b0;
  logic              rst, load, sdi_valid, start, correct;
  logic [BUSW-1:0]   sdi;
  logic              sdi_ready;
  logic [TW-1:0]     tkxtbc, tkxcorrect, tkx;
  logic [SHARES-1:0] ring_en;
  logic [5:0]        round_cnt;
  logic              busy, done;
`ifdef TKX_SHARE_BANK_REFRESH_EN
  logic              refresh;
  logic [127:0]      rdi;
`endif

  int total = 0;
  int bad   = 0;

  logic [TW-1:0]     tkx_q[$];
  logic [SHARES-1:0] ring_q[$];

  always #5 clk = ~clk;

  // Stand-ins for the round function and correction logic.
  always_comb begin
    for (int j = 0; j < SHARES; j++) begin
      tkxtbc[128*j +: 128]     = tkx[128*j +: 128] + 128'd1;
      tkxcorrect[128*j +: 128] = tkx[128*j +: 128] ^ CMASK;
    end
  end

  tkx_share_bank #(.SHARES(SHARES), .BUSW(BUSW), .NROUNDS(NROUNDS)) dut (
    .clk(clk), .rst(rst), .load(load), .sdi(sdi), .sdi_valid(sdi_valid),
    .sdi_ready(sdi_ready), .start(start), .correct(correct),
    .tkxtbc(tkxtbc), .tkxcorrect(tkxcorrect),
`ifdef TKX_SHARE_BANK_REFRESH_EN
    .refresh(refresh), .rdi(rdi),
`endif
    .tkx(tkx), .ring_en(ring_en), .round_cnt(round_cnt), .busy(busy), .done(done)
  );

  typedef struct {
    logic [TW-1:0] key;
    bit            corr;
    int            exp_busy;
    logic [5:0]    exp_round;
    logic [TW-1:0] exp_tkx;
  } vec_t;

  vec_t vecs[3];

  task automatic chk(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [TW-1:0] m_tbc(input logic [TW-1:0] key, input bit c);
    logic [TW-1:0] r;
    logic [127:0]  s;
    for (int j = 0; j < SHARES; j++) begin
      s = key[128*j +: 128] + 128'(NROUNDS);
      if (c) s = s ^ CMASK;
      r[128*j +: 128] = s;
    end
    return r;
  endfunction

  task automatic do_load(input logic [TW-1:0] key, input bit stall, input bit with_start,
                         input int exp_busy);
    int i, n, ph, guard;
    i = 0; n = 0; ph = 0; guard = 0;
    tkx_q.push_back(key);
    @(negedge clk);
    load = 1'b1;
    start = with_start;
    @(negedge clk);
    load = 1'b0;
    start = 1'b0;
    chk("sdi_ready_in_load", TW'(sdi_ready), TW'(1));
    chk("no_tbc_on_load", TW'(ring_en), '0);
    while (i < TW / BUSW && guard < 100) begin
      if (busy) n++;
      sdi_valid = !stall || (ph % 2 == 0);
      sdi = key[TW-1-BUSW*i -: BUSW];
      if (sdi_valid) i++;
      ph++;
      guard++;
      @(negedge clk);
    end
    sdi_valid = 1'b0;
    chk("load_busy_cycles", TW'(n), TW'(exp_busy));
    chk("load_done", TW'(done), TW'(1));
    chk("load_ready_after", TW'(sdi_ready), '0);
    if (tkx_q.size() > 0) chk("load_tkx", tkx, tkx_q.pop_front());
    else chk("load_q_empty", TW'(1), '0);
    @(negedge clk);
    chk("load_done_pulse", TW'(done), '0);
  endtask

  task automatic run_tbc(input bit c, input int exp_busy, input logic [5:0] exp_round,
                         input logic [TW-1:0] exp_tkx);
    int n, guard;
    n = 0; guard = 0;
    @(negedge clk);
    start = 1'b1;
    correct = c;
    for (int i = 0; i < NROUNDS * SHARES + (c ? SHARES : 0); i++)
      ring_q.push_back(SHARES'(1) << (i % SHARES));
    tkx_q.push_back(exp_tkx);
    @(negedge clk);
    start = 1'b0;
    correct = 1'b0;
    while (busy && guard < 500) begin
      if (ring_q.size() > 0) chk("ring_en", TW'(ring_en), TW'(ring_q.pop_front()));
      else chk("ring_extra_cycle", TW'(ring_en), '0);
      if (n == 5) chk("sdi_ready_in_tbc", TW'(sdi_ready), '0);
      load = (n == 5);
      n++;
      guard++;
      @(negedge clk);
    end
    load = 1'b0;
    chk("tbc_busy_cycles", TW'(n), TW'(exp_busy));
    chk("tbc_done", TW'(done), TW'(1));
    chk("tbc_round_cnt", TW'(round_cnt), TW'(exp_round));
    chk("tbc_ring_idle", TW'(ring_en), '0);
    chk("tbc_ring_q_drained", TW'(ring_q.size()), '0);
    if (tkx_q.size() > 0) chk("tbc_tkx", tkx, tkx_q.pop_front());
    else chk("tbc_q_empty", TW'(1), '0);
    @(negedge clk);
    chk("tbc_done_pulse", TW'(done), '0);
    chk("round_cnt_holds", TW'(round_cnt), TW'(exp_round));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [TW-1:0] key_seq;
    int guard;
    key_seq = 256'h00000001_00000002_00000003_00000004_00000005_00000006_00000007_00000008;

    vecs[0].key = {128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF, 128'h1};
    vecs[0].corr = 1'b0;
    vecs[1].key = {128'hDEAD_BEEF_0000_0000_0000_0000_0000_0100, 128'h5A5A};
    vecs[1].corr = 1'b1;
    vecs[2].key = {128'h7, {128{1'b1}}};
    vecs[2].corr = 1'b0;
    for (int v = 0; v < 3; v++) begin
      vecs[v].exp_busy  = NROUNDS * SHARES + (vecs[v].corr ? SHARES : 0);
      vecs[v].exp_round = 6'(NROUNDS);
      vecs[v].exp_tkx   = m_tbc(vecs[v].key, vecs[v].corr);
    end

    rst = 1'b0; load = 1'b0; start = 1'b0; correct = 1'b0; sdi_valid = 1'b0; sdi = '0;
`ifdef TKX_SHARE_BANK_REFRESH_EN
    refresh = 1'b0; rdi = '0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_tkx", tkx, '0);
    chk("rst_ring", TW'(ring_en), '0);
    chk("rst_round", TW'(round_cnt), '0);
    chk("rst_busy", TW'(busy), '0);
    chk("rst_done", TW'(done), '0);
    chk("rst_ready", TW'(sdi_ready), '0);
    rst = 1'b1;

    do_load(key_seq, 1'b0, 1'b0, 8);
    do_load(key_seq, 1'b1, 1'b0, 15);

    for (int v = 0; v < 3; v++) begin
      do_load(vecs[v].key, 1'b0, 1'b0, 8);
      run_tbc(vecs[v].corr, vecs[v].exp_busy, vecs[v].exp_round, vecs[v].exp_tkx);
    end

    do_load(key_seq, 1'b0, 1'b0, 8);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (round_cnt != 6'd17 && guard < 200) begin
      guard++;
      @(negedge clk);
    end
    chk("reach_round17", TW'(round_cnt), TW'(17));
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("midrst_tkx", tkx, '0);
    chk("midrst_ring", TW'(ring_en), '0);
    chk("midrst_round", TW'(round_cnt), '0);
    chk("midrst_busy", TW'(busy), '0);
    @(negedge clk);
    chk("midrst_stays_idle", TW'(busy), '0);

    do_load(key_seq, 1'b0, 1'b1, 8);

`ifdef TKX_SHARE_BANK_REFRESH_EN
    begin
      logic [TW-1:0] before;
      before = tkx;
      rdi = {16{8'hA5}};
      refresh = 1'b1;
      @(negedge clk);
      refresh = 1'b0;
      chk("refresh_xor_inv", TW'(tkx[127:0] ^ tkx[255:128]), TW'(before[127:0] ^ before[255:128]));
      chk("refresh_share0", TW'(tkx[127:0] ^ before[127:0]), TW'(rdi));
      chk("refresh_share1", TW'(tkx[255:128] ^ before[255:128]), TW'(rdi));
      chk("refresh_no_busy", TW'(busy), '0);
      chk("refresh_no_done", TW'(done), '0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tkx_share_bank.md
Name: tkx_share_bank

Overview:
Parametrised successor to the single/dual-share TK1 key register. It holds SHARES Boolean shares of the 128-bit key.
- Loads the shares serially over the BUSW key bus with a valid/ready handshake.
- Sequences one share update per clock during the TBC and drives the one-hot ring_en that the round function consumes.
- Optionally runs a post-TBC correction pass, one share per cycle.
- Sits between the key input bus and the masked Skinny round/correction logic in the Romulus datapath.

Parameters:
SHARES, 2, number of key shares (1..4); tkx width is 128*SHARES.
BUSW, 32, key bus width; 128*SHARES must be a multiple of BUSW.
NROUNDS, 40, TBC rounds per invocation (1..63).

Ports:
clk  in  1  clock, all logic on rising edge.
rst  in  1  synchronous reset, active-low, sampled on rising clk.
load  in  1  pulse in IDLE: begin serial key load.
sdi  in  BUSW  key word.
sdi_valid  in  1  sdi word valid.
sdi_ready  out  1  high only in LOAD.
start  in  1  pulse in IDLE: begin TBC.
correct  in  1  sampled with start: 1 = run CORRECT after TBC.
tkxtbc  in  128*SHARES  next-round key shares from the round function.
tkxcorrect  in  128*SHARES  corrected key shares from the correction logic.
tkx  out  128*SHARES  current shares; share j = bits [128j+127:128j].
ring_en  out  SHARES  one-hot active share, zero outside TBC/CORRECT.
round_cnt  out  6  completed TBC rounds.
busy  out  1  high in LOAD, TBC, CORRECT.
done  out  1  one-cycle pulse on return to IDLE from TBC/CORRECT/LOAD.

Behaviour:
- Reset (rst=0 at an edge), from any state including mid-operation:
  - FSM goes to IDLE.
  - tkx, ring_en, round_cnt, busy, done, word counter and share pointer all clear to 0.
  - The next operation needs a fresh load/start.
- States: IDLE, LOAD, TBC, CORRECT.
- IDLE:
  - load=1 -> LOAD.
  - else start=1 -> TBC; latch correct.
  - load has priority over start.
  - load/start are ignored in any non-IDLE state.
- LOAD:
  - On each cycle with sdi_valid=1 (sdi_ready is 1): tkx <= {tkx[128*SHARES-BUSW-1:0], sdi}. The first word ends up in the MSBs.
  - When BUSW = 128*SHARES: tkx <= sdi.
  - After W = 128*SHARES/BUSW accepted words -> IDLE with done=1.
  - Valid-low cycles stall without changing state.
- TBC:
  - Share pointer p starts at 0; ring_en = 1<<p.
  - Each cycle share p <= tkxtbc share p; other shares hold.
  - p increments mod SHARES.
  - When p wraps to 0, round_cnt increments.
  - When round_cnt reaches NROUNDS (wrap completing the last round): go to CORRECT if latched correct=1, else IDLE with done=1.
  - TBC lasts exactly NROUNDS*SHARES cycles.
- CORRECT:
  - Same one-hot sequencing, but share p <= tkxcorrect share p.
  - Lasts SHARES cycles, then IDLE with done=1.
  - round_cnt holds its final value.
- round_cnt:
  - Cleared when start is accepted.
  - Holds in IDLE; readable after done.
- Latency: with start accepted at edge k:
  - busy=1 for cycles k+1 .. k+NROUNDS*SHARES+(correct?SHARES:0).
  - done=1 in the following cycle.
  - busy=0 whenever done=1.
- SHARES=1: ring_en is constantly 1 in TBC/CORRECT and each round is one cycle.

Optional Feature:
TKX_SHARE_BANK_REFRESH_EN
- Defined:
  - Adds ports refresh (in, 1) and rdi (in, 128).
  - refresh=1 in IDLE (priority below load and start): share0 ^= rdi and share1 ^= rdi in one cycle; the XOR of all shares is unchanged. No busy or done.
  - Only legal with SHARES>=2; the refresh input is ignored when SHARES=1.
- Undefined: these ports do not exist and no refresh logic is built.

Test Plan:
- Load, SHARES=2, BUSW=32:
  - Stimulus: 8 words 0x00000001..0x00000008 with valid held high.
  - Required: tkx = 0x00000001_00000002_..._00000008; done pulses one cycle after word 8; sdi_ready low afterwards.
- Stalled load:
  - Stimulus: the same 8 words with sdi_valid low on alternating cycles.
  - Required: the same final tkx; busy stays high for 15 cycles.
- TBC without correction, NROUNDS=40, SHARES=2:
  - Stimulus: start=1, correct=0, tkxtbc driven as tkx+1 per share.
  - Required: ring_en alternates 01,10; busy high 80 cycles; round_cnt=40 at done; each share incremented by 40.
- TBC with correction:
  - Stimulus: start=1, correct=1.
  - Required: busy high 82 cycles; final two cycles load tkxcorrect into share0 then share1; done at cycle 83.
- Reset mid-TBC and priority:
  - Stimulus: rst=0 at round 17.
  - Required: tkx=0, ring_en=0, round_cnt=0, IDLE the next cycle.
  - Stimulus: load and start asserted together in IDLE.
  - Required: LOAD is entered.
- Refresh (macro defined):
  - Stimulus: refresh with rdi=0xA5..A5.
  - Required: share0^share1 unchanged; both shares differ from their prior values by 0xA5..A5.
